// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: ALU operation classes, ALU control codes, R-type funct values,
// the ID/EX register layout and the operand-forwarding selection helper.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_RTYPE = 2'b10,
      ALU_OP_PASS  = 2'b11
   } alu_op_e;

   localparam logic [3:0] ALUC_AND    = 4'b0000;
   localparam logic [3:0] ALUC_OR     = 4'b0001;
   localparam logic [3:0] ALUC_ADD    = 4'b0010;
   localparam logic [3:0] ALUC_SUB    = 4'b0110;
   localparam logic [3:0] ALUC_SLT    = 4'b0111;
   localparam logic [3:0] ALUC_PASS_A = 4'b1111;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        alu_src;
      logic        reg_dst;
      logic [3:0]  alu_ctrl;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } id_ex_t;

   localparam int ID_EX_W = $bits(id_ex_t);

   // MEM is the younger producer, so it wins; $0 is hard-wired and never forwarded.
   function automatic logic [31:0] forward_operand(
      input logic        mem_we,
      input logic [4:0]  mem_dst,
      input logic [31:0] mem_val,
      input logic        wb_we,
      input logic [4:0]  wb_dst,
      input logic [31:0] wb_val,
      input logic [4:0]  src,
      input logic [31:0] reg_val
   );
      logic [31:0] res;
      if (mem_we && (mem_dst != REG_ZERO) && (mem_dst == src)) begin
         res = mem_val;
      end else if (wb_we && (wb_dst != REG_ZERO) && (wb_dst == src)) begin
         res = wb_val;
      end else begin
         res = reg_val;
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALU control decode from operation class and R-type funct field.
module alu_control_decode
   import pipeline_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_control
);

   // Unknown R-type functs fall back to pass-a so they cannot corrupt state silently.
   always_comb begin
      alu_control = ALUC_PASS_A;
      case (alu_op)
         ALU_OP_ADD:   alu_control = ALUC_ADD;
         ALU_OP_SUB:   alu_control = ALUC_SUB;
         ALU_OP_RTYPE: begin
            case (funct)
               FUNCT_ADD: alu_control = ALUC_ADD;
               FUNCT_SUB: alu_control = ALUC_SUB;
               FUNCT_AND: alu_control = ALUC_AND;
               FUNCT_OR:  alu_control = ALUC_OR;
               FUNCT_SLT: alu_control = ALUC_SLT;
               default:   alu_control = ALUC_PASS_A;
            endcase
         end
         ALU_OP_PASS:  alu_control = ALUC_PASS_A;
         default:      alu_control = ALUC_PASS_A;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control, EX-stage operand forwarding
// and load-use hazard detection.
module id_ex_stage
   import pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_valid,
   input  logic        id_alu_src,
   input  logic        id_reg_dst,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_mem_to_reg,
   input  logic [1:0]  id_alu_op,
   input  logic [5:0]  id_funct,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        mem_reg_write,
   input  logic        wb_reg_write,
   input  logic [4:0]  mem_rd,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] mem_result,
   input  logic [31:0] wb_result,
   output logic [3:0]  ex_alu_control,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [31:0] ex_write_data,
   output logic [4:0]  ex_dest,
   output logic        ex_valid,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic        load_use_stall
);

   id_ex_t      ex_q;
   id_ex_t      ex_d;
   logic [3:0]  dec_alu_ctrl;
   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;

   alu_control_decode u_alu_control_decode (
      .alu_op      (id_alu_op),
      .funct       (id_funct),
      .alu_control (dec_alu_ctrl)
   );

   // Next-state: flush beats stall; an invalid slot never carries live enables.
   always_comb begin
      ex_d = ex_q;
      if (flush) begin
         ex_d = {ID_EX_W{1'b0}};
      end else if (stall) begin
         ex_d = ex_q;
      end else begin
         ex_d.valid      = id_valid;
         ex_d.reg_write  = id_valid & id_reg_write;
         ex_d.mem_read   = id_valid & id_mem_read;
         ex_d.mem_write  = id_valid & id_mem_write;
         ex_d.mem_to_reg = id_valid & id_mem_to_reg;
         ex_d.alu_src    = id_valid & id_alu_src;
         ex_d.reg_dst    = id_valid & id_reg_dst;
         ex_d.alu_ctrl   = dec_alu_ctrl;
         ex_d.rs_data    = id_rs_data;
         ex_d.rt_data    = id_rt_data;
         ex_d.imm        = id_imm;
         ex_d.rs         = id_rs;
         ex_d.rt         = id_rt;
         ex_d.rd         = id_rd;
      end
   end

   // Pipeline register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q <= {ID_EX_W{1'b0}};
      end else begin
         ex_q <= ex_d;
      end
   end

   assign fwd_rs = forward_operand(mem_reg_write, mem_rd, mem_result,
                                   wb_reg_write, wb_rd, wb_result,
                                   ex_q.rs, ex_q.rs_data);
   assign fwd_rt = forward_operand(mem_reg_write, mem_rd, mem_result,
                                   wb_reg_write, wb_rd, wb_result,
                                   ex_q.rt, ex_q.rt_data);

   assign ex_alu_control = ex_q.alu_ctrl;
   assign ex_a           = fwd_rs;
   assign ex_b           = ex_q.alu_src ? ex_q.imm : fwd_rt;
   assign ex_write_data  = fwd_rt;
   assign ex_dest        = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
   assign ex_valid       = ex_q.valid;
   assign ex_reg_write   = ex_q.reg_write;
   assign ex_mem_read    = ex_q.mem_read;
   assign ex_mem_write   = ex_q.mem_write;
   assign ex_mem_to_reg  = ex_q.mem_to_reg;

   // Load result is not available until after MEM, so a dependent decode must wait.
   assign load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.rt != REG_ZERO) & id_valid
                         & ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports stall, flush  input  1 each  hold contents / insert bubble.
REQ-004 SHALL have ports id_valid, id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  decode-stage controls.
REQ-005 SHALL have ports id_alu_op  input  2  and id_funct  input  6  ALU operation class and R-type funct.
REQ-006 SHALL have ports id_rs_data, id_rt_data, id_imm  input  32 each  register operands, sign-extended immediate.
REQ-007 SHALL have ports id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-008 SHALL have ports mem_reg_write, wb_reg_write  input  1; mem_rd, wb_rd  input  5; mem_result, wb_result  input  32  forwarding sources.
REQ-009 SHALL have outputs ex_alu_control  4, ex_a  32, ex_b  32  operands and opcode driving the ALU.
REQ-010 SHALL have outputs ex_write_data  32, ex_dest  5, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  1 each  to EX/MEM.
REQ-011 SHALL have output load_use_stall  1  combinational hazard request to decode/PC.

Function
REQ-012 On a clock edge with flush=1, all registered fields SHALL be zeroed (bubble, ex_valid=0); flush SHALL take priority over stall.
REQ-013 With flush=0, stall=1, all registered fields SHALL hold their values.
REQ-014 With flush=0, stall=0, all id_* fields SHALL be captured; ex_valid SHALL take id_valid; when id_valid=0 control bits SHALL be captured as 0.
REQ-015 ALU control SHALL be decoded before capture (one-cycle latency) and registered: alu_op 00 -> 0010 (add); 01 -> 0110 (sub); 10 -> by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, other -> 1111; alu_op 11 -> 1111 (ALU passes a).
REQ-016 Forwarded rs SHALL be mem_result if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs, else wb_result if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs, else registered rs_data; identically for rt. MEM SHALL win over WB.
REQ-017 ex_a SHALL equal forwarded rs; ex_b SHALL equal registered imm if alu_src=1, else forwarded rt; ex_write_data SHALL equal forwarded rt regardless of alu_src.
REQ-018 ex_dest SHALL be registered rd if reg_dst=1, else registered rt.
REQ-019 Forwarding paths SHALL be combinational from registered specifiers and current-cycle mem/wb inputs (zero-cycle latency).
REQ-020 load_use_stall SHALL be 1 iff ex_valid && ex_mem_read && ex_rt!=0 && id_valid && (ex_rt==id_rs || ex_rt==id_rt); the block SHALL NOT self-stall—external logic drives flush=1 on the following edge.
REQ-021 Register $0 SHALL never be a forwarding source, even if mem/wb claim to write it.

Reset
REQ-022 While rst_n=0, all registered fields SHALL be 0 immediately (asynchronous), giving ex_alu_control=0000, ex_valid=0, all write/mem enables 0.
REQ-023 Reset asserted mid-stall SHALL discard held contents; after release, the first edge SHALL follow REQ-012..014.

Structure
REQ-024 A shared package pipeline_pkg SHALL hold ALU control encodings, alu_op encodings and funct constants, shared with the ALU.
REQ-025 ALU control decode SHALL be a combinational sub-module alu_control_decode (alu_op, funct -> 4-bit control).
REQ-026 Expected size 120-250 lines; no memories; one always block for state with async reset.

Verification
REQ-027 Reset: rst_n=0 with arbitrary inputs -> all outputs 0 immediately, load_use_stall=0.
REQ-028 R-type capture: alu_op=10, funct=101010, rs_data=5, rt_data=9, reg_dst=1, rd=7 -> next cycle ex_alu_control=0111, ex_a=5, ex_b=9, ex_dest=7.
REQ-029 Forward priority: ex_rs=3, mem_rd=3 mem_result=0xAA, wb_rd=3 wb_result=0xBB, both write enables 1 -> ex_a=0xAA; drop mem_reg_write -> ex_a=0xBB; mem_rd=0 with rs=0 -> no forwarding.
REQ-030 Load-use: EX holds lw (mem_read=1, rt=4), ID id_rs=4 id_valid=1 -> load_use_stall=1; stall+flush next edge -> ex_valid=0, all enables 0.
REQ-031 Stall/flush priority: stall=1 holds 3 cycles unchanged; stall=1 and flush=1 together -> bubble.
REQ-032 I-type: alu_op=00, alu_src=1, imm=0xFFFFFFFC, rt_data=0x10, reg_dst=0, rt=8 -> ex_alu_control=0010, ex_b=0xFFFFFFFC, ex_write_data=0x10, ex_dest=8.
